// File: rtl/matmul2x2_sequencer_if.sv
// rtl/matmul2x2_sequencer_if.sv - host handshake plus shared multiplier/adder bus for the 2x2 matmul sequencer
// abort exists only when MATSEQ_ABORT_EN is defined.
interface matmul2x2_sequencer_if;
    logic        start;
    logic [15:0] a_flat;
    logic [15:0] b_flat;
`ifdef MATSEQ_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        done;
    logic [35:0] c_flat;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic [7:0]  mul_p;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [8:0]  add_sum;

    modport slave (
        input  start, a_flat, b_flat, mul_p, add_sum,
`ifdef MATSEQ_ABORT_EN
        input  abort,
`endif
        output busy, done, c_flat, mul_x, mul_y, add_a, add_b
    );

    modport master (
        output start, a_flat, b_flat, mul_p, add_sum,
`ifdef MATSEQ_ABORT_EN
        output abort,
`endif
        input  busy, done, c_flat, mul_x, mul_y, add_a, add_b
    );
endinterface

// File: rtl/matmul2x2_sequencer.sv
// rtl/matmul2x2_sequencer.sv - 2x2 unsigned 4-bit matrix multiply sequencer time-sharing one multiplier and one adder
// Optional abort support is enabled by defining MATSEQ_ABORT_EN.
module matmul2x2_sequencer (
    input  logic                 clk,
    input  logic                 rst_n,
    matmul2x2_sequencer_if.slave ifc
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL0 = 3'd1,
        S_MUL1 = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  p0_q, p0_d;
    logic [7:0]  p1_q, p1_d;
    logic [35:0] c_q, c_d;

    logic        abort_req;
    logic [3:0]  a_i0, a_i1, b_0j, b_1j;

`ifdef MATSEQ_ABORT_EN
    assign abort_req = ifc.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Row i of A comes from idx[1], column j of B from idx[0].
    always_comb begin
        a_i0 = idx_q[1] ? a_q[11:8]  : a_q[3:0];
        a_i1 = idx_q[1] ? a_q[15:12] : a_q[7:4];
        b_0j = idx_q[0] ? b_q[7:4]   : b_q[3:0];
        b_1j = idx_q[0] ? b_q[15:12] : b_q[11:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            p0_q    <= 8'd0;
            p1_q    <= 8'd0;
            c_q     <= 36'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (ifc.start) begin
                    a_d     = ifc.a_flat;
                    b_d     = ifc.b_flat;
                    c_d     = 36'd0;
                    idx_d   = 2'd0;
                    state_d = S_MUL0;
                end
            end
            S_MUL0: begin
                p0_d    = ifc.mul_p;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                p1_d    = ifc.mul_p;
                state_d = S_ACC;
            end
            S_ACC: begin
                case (idx_q)
                    2'd0:    c_d[8:0]   = ifc.add_sum;
                    2'd1:    c_d[17:9]  = ifc.add_sum;
                    2'd2:    c_d[26:18] = ifc.add_sum;
                    default: c_d[35:27] = ifc.add_sum;
                endcase
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_MUL0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An abort discards this cycle's work; elements written earlier stay.
        if (abort_req && (state_q == S_MUL0 || state_q == S_MUL1 || state_q == S_ACC)) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            p0_d    = p0_q;
            p1_d    = p1_q;
            c_d     = c_q;
        end
    end

    always_comb begin
        ifc.busy  = 1'b0;
        ifc.done  = 1'b0;
        ifc.mul_x = 4'd0;
        ifc.mul_y = 4'd0;
        ifc.add_a = 8'd0;
        ifc.add_b = 8'd0;
        case (state_q)
            S_MUL0: begin
                ifc.busy  = 1'b1;
                ifc.mul_x = a_i0;
                ifc.mul_y = b_0j;
            end
            S_MUL1: begin
                ifc.busy  = 1'b1;
                ifc.mul_x = a_i1;
                ifc.mul_y = b_1j;
            end
            S_ACC: begin
                ifc.busy  = 1'b1;
                ifc.add_a = p0_q;
                ifc.add_b = p1_q;
            end
            S_DONE:  ifc.done = 1'b1;
            default: ;
        endcase
    end

    assign ifc.c_flat = c_q;

endmodule

// File: tb/tb_matmul2x2_sequencer.sv
// tb/tb_matmul2x2_sequencer.sv - randomized self-checking bench for matmul2x2_sequencer against a matrix-level model
module tb_matmul2x2_sequencer;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    matmul2x2_sequencer_if ifc();

    assign ifc.mul_p   = ifc.mul_x * ifc.mul_y;
    assign ifc.add_sum = {1'b0, ifc.add_a} + {1'b0, ifc.add_b};

    matmul2x2_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1..12 busy (three phases per element), 13 done.
    int         ph = 0;
    logic [3:0] ma [2][2];
    logic [3:0] mb [2][2];
    logic [8:0] mc [4];

    function automatic logic [8:0] elem(input int e);
        int i, j;
        i = e / 2;
        j = e % 2;
        return 9'(int'(ma[i][0]) * int'(mb[0][j]) + int'(ma[i][1]) * int'(mb[1][j]));
    endfunction

    function automatic logic [35:0] ref_c(input logic [15:0] a, input logic [15:0] b);
        logic [35:0] r;
        for (int e = 0; e < 4; e++) begin
            int i, j, v;
            i = e / 2;
            j = e % 2;
            v = int'(a[(i*2)*4 +: 4]) * int'(b[j*4 +: 4]) + int'(a[(i*2+1)*4 +: 4]) * int'(b[(2+j)*4 +: 4]);
            r[e*9 +: 9] = 9'(v);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic ab;
`ifdef MATSEQ_ABORT_EN
        ab = ifc.abort;
`else
        ab = 1'b0;
`endif
        if (!rst_n) begin
            ph = 0;
            for (int e = 0; e < 4; e++) mc[e] = 9'd0;
        end else if (ph == 0) begin
            if (ifc.start) begin
                ma[0][0] = ifc.a_flat[3:0];   ma[0][1] = ifc.a_flat[7:4];
                ma[1][0] = ifc.a_flat[11:8];  ma[1][1] = ifc.a_flat[15:12];
                mb[0][0] = ifc.b_flat[3:0];   mb[0][1] = ifc.b_flat[7:4];
                mb[1][0] = ifc.b_flat[11:8];  mb[1][1] = ifc.b_flat[15:12];
                for (int e = 0; e < 4; e++) mc[e] = 9'd0;
                ph = 1;
            end
        end else if (ph == 13) begin
            ph = 0;
        end else if (ab) begin
            ph = 0;
        end else begin
            if ((ph - 1) % 3 == 2) mc[(ph - 1) / 3] = elem((ph - 1) / 3);
            ph++;
        end
    end

    always @(negedge clk) begin
        int e, s, i, j;
        logic [3:0] ex, ey;
        logic [7:0] ea, eb;
        ex = 4'd0; ey = 4'd0; ea = 8'd0; eb = 8'd0;
        if (ph >= 1 && ph <= 12) begin
            e = (ph - 1) / 3;
            s = (ph - 1) % 3;
            i = e / 2;
            j = e % 2;
            if (s == 0) begin
                ex = ma[i][0]; ey = mb[0][j];
            end else if (s == 1) begin
                ex = ma[i][1]; ey = mb[1][j];
            end else begin
                ea = 8'(int'(ma[i][0]) * int'(mb[0][j]));
                eb = 8'(int'(ma[i][1]) * int'(mb[1][j]));
            end
        end
        chk("busy", ifc.busy, (ph >= 1 && ph <= 12));
        chk("done", ifc.done, (ph == 13));
        chk("c_flat", ifc.c_flat, {mc[3], mc[2], mc[1], mc[0]});
        chk("mul_xy", {ifc.mul_x, ifc.mul_y}, {ex, ey});
        chk("add_ab", {ifc.add_a, ifc.add_b}, {ea, eb});
    end

    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           output int busy_n, output int done_n, output logic [35:0] c);
        ifc.a_flat = a;
        ifc.b_flat = b;
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
        busy_n = 0;
        done_n = 0;
        c = 36'd0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ifc.busy) busy_n++;
            if (ifc.done) begin
                done_n = n;
                c = ifc.c_flat;
                break;
            end
        end
        chk("done_seen", (done_n != 0), 1);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (ifc.done) cnt++;
        end
    endtask

    initial begin
        int bn, dn, cnt, first_n, second_n;
        logic [35:0] c, first_c;
        logic [15:0] ra, rb;

        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.a_flat = 16'd0;
        ifc.b_flat = 16'd0;
`ifdef MATSEQ_ABORT_EN
        ifc.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_c", ifc.c_flat, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_one(16'h4321, 16'h8765, bn, dn, c);
        chk("t1_busy_cycles", bn, 12);
        chk("t1_done_cycle", dn, 13);
        chk("t1_c", c, {9'd50, 9'd43, 9'd22, 9'd19});
        @(negedge clk);
        chk("t1_done_single", ifc.done, 0);

        run_one(16'hFFFF, 16'hFFFF, bn, dn, c);
        chk("t2_c_max", c, {4{9'h1C2}});

        // Start held for 20 cycles: one run, then a second accepted right after DONE.
        ifc.a_flat = 16'h1001;
        ifc.b_flat = 16'hCBA9;
        @(posedge clk); #1 ifc.start = 1'b1;
        cnt = 0; first_n = -1; second_n = -1; first_c = 36'd0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (n == 5) ifc.a_flat = 16'($urandom);
            if (n == 19) ifc.start = 1'b0;
            @(negedge clk);
            if (ifc.done) begin
                cnt++;
                if (first_n < 0) begin
                    first_n = n;
                    first_c = ifc.c_flat;
                end else begin
                    second_n = n;
                end
            end
        end
        chk("t3_done_count", cnt, 2);
        chk("t3_first_done", first_n, 12);
        chk("t3_second_done", second_n, 26);
        chk("t3_c_eq_b", first_c, {9'd12, 9'd11, 9'd10, 9'd9});

        // Reset in the middle of a run.
        ifc.a_flat = 16'($urandom) | 16'h1111;
        ifc.b_flat = 16'($urandom) | 16'h1111;
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", ifc.busy, 0);
        chk("t4_rst_done", ifc.done, 0);
        chk("t4_rst_c", ifc.c_flat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(20, cnt);
        chk("t4_no_done", cnt, 0);
        ra = 16'($urandom);
        rb = 16'($urandom);
        run_one(ra, rb, bn, dn, c);
        chk("t4_after_c", c, ref_c(ra, rb));

`ifdef MATSEQ_ABORT_EN
        ifc.a_flat = 16'h4321;
        ifc.b_flat = 16'h8765;
        @(posedge clk); #1 ifc.start = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0;
        repeat (6) @(posedge clk);
        #1 ifc.abort = 1'b1;
        @(posedge clk); #1 ifc.abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_busy", ifc.busy, 0);
        chk("t5_abort_c", ifc.c_flat, {18'd0, 9'd22, 9'd19});
        count_done(20, cnt);
        chk("t5_no_done", cnt, 0);
`endif

        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_one(ra, rb, bn, dn, c);
            chk("rand_busy_cycles", bn, 12);
            chk("rand_done_cycle", dn, 13);
            chk("rand_c", c, ref_c(ra, rb));
        end

        // Free-running random traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            ifc.start  = ($urandom_range(0, 3) == 0);
            ifc.a_flat = 16'($urandom);
            ifc.b_flat = 16'($urandom);
`ifdef MATSEQ_ABORT_EN
            ifc.abort  = ($urandom_range(0, 15) == 0);
`endif
        end
        @(posedge clk); #1;
        ifc.start = 1'b0;
`ifdef MATSEQ_ABORT_EN
        ifc.abort = 1'b0;
`endif
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul2x2_sequencer.md
# matmul2x2_sequencer

Sequencer for the 2x2 matrix multiplier datapath. It computes C = A x B for unsigned 4-bit elements by time-sharing one external 4x4 multiplier and one external 8-bit ripple adder (8-bit operands, 9-bit sum with carry-out). The block owns the operand registers, product holding registers and result registers, and presents a start/busy/done handshake to the host logic.

## Interface
Parameters:
- none; widths are fixed: 4-bit elements, 8-bit products, 9-bit results.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply. Sampled only in IDLE.
- `a_flat`  in  16  matrix A. [3:0]=a00, [7:4]=a01, [11:8]=a10, [15:12]=a11.
- `b_flat`  in  16  matrix B, same packing as A.
- `abort`  in  1  cancel the operation. Present only with `MATSEQ_ABORT_EN`.
- `busy`  out  1  high in MUL0, MUL1 and ACC.
- `done`  out  1  one-cycle pulse when the result is complete.
- `c_flat`  out  36  result. [8:0]=c00, [17:9]=c01, [26:18]=c10, [35:27]=c11.
- `mul_x`, `mul_y`  out  4 each  shared multiplier operands.
- `mul_p`  in  8  multiplier product. Combinational, same cycle.
- `add_a`, `add_b`  out  8 each  shared adder operands.
- `add_sum`  in  9  adder result including carry. Combinational, same cycle.

## Operation
- States: IDLE, MUL0, MUL1, ACC, DONE. Element index `idx` is 2 bits and runs 0..3 in the order c00, c01, c10, c11. For each idx, i = idx[1] and j = idx[0].
- IDLE, when `start`=1:
  - latch a_flat and b_flat;
  - clear c_flat to 0;
  - set idx=0;
  - go to MUL0.
- MUL0: mul_x=A[i][0], mul_y=B[0][j]. Register p0<=mul_p. Go to MUL1.
- MUL1: mul_x=A[i][1], mul_y=B[1][j]. Register p1<=mul_p. Go to ACC.
- ACC: add_a=p0, add_b=p1. Register c[idx]<=add_sum.
  - If idx=3, go to DONE.
  - Otherwise idx<=idx+1 and go to MUL0.
- DONE: done=1, busy=0. Go to IDLE unconditionally.
- Arithmetic: results are unsigned. The maximum is 15·15 + 15·15 = 450 (0x1C2), which fits 9 bits. No overflow or saturation is possible.
- Shared-resource outputs (mul_x, mul_y, add_a, add_b) are 0 in any state that does not use them.
- `start` outside IDLE is ignored, including in DONE. Input matrices are not re-sampled while busy.
- c_flat updates one element at a time and is only guaranteed complete when `done`=1. It holds its value in IDLE until the next accepted start.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, idx=0, p0=p1=0;
  - c_flat=0, busy=0, done=0;
  - mul_x, mul_y, add_a and add_b are 0.
- Release from reset is synchronous to the next rising edge.
- Start sampled at edge E0:
  - busy=1 from E0 through E12 (12 cycles, 3 per element);
  - done=1 for the single cycle after E12;
  - IDLE from E13 onward.
- Start-to-start minimum spacing: 14 cycles.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. No done pulse is produced.

## Configuration
- `MATSEQ_ABORT_EN` defined:
  - The `abort` port exists.
  - abort=1 sampled in MUL0, MUL1 or ACC forces IDLE on the next edge, with no done pulse.
  - c_flat keeps any elements already written.
  - abort in IDLE or DONE is ignored. Start and abort together in IDLE means the start is accepted.
- `MATSEQ_ABORT_EN` not defined: no `abort` port, and every accepted start runs to DONE.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], start for 1 cycle:
  - result c00=19, c01=22, c10=43, c11=50;
  - busy high for exactly 12 cycles;
  - done a single pulse on cycle 13.
- A=B=all 15 → every element = 450 (0x1C2). Checks that carry-out lands in bit 8.
- A=identity, B=[[9,10],[11,12]] → C=B. Hold start high for 20 cycles → exactly one operation plus a second one accepted after DONE→IDLE. a_flat changed mid-run has no effect on the result.
- rst_n pulsed low at cycle 5 of a run:
  - busy, done and c_flat go to 0 immediately;
  - no done pulse follows;
  - a new start then completes correctly.
- With `MATSEQ_ABORT_EN`: abort at cycle 7 → busy falls next cycle and no done. c00 and c01 hold their computed values, c10 and c11 remain 0.
- Shared-resource check: mul_x/mul_y are nonzero only in MUL0/MUL1, and add_a/add_b only in ACC, for a nonzero-operand run.
